seq_multiplier: RTL
===================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand width in bits; legal values are 4 to 32.
REQ-002 Parameter BITS_PER_CYCLE, default 1, SHALL set the multiplier bits retired per cycle; legal values are 1, 2 and 4, and the value SHALL divide WIDTH.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operands and mode are presented.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 A  input  WIDTH  multiplicand.
REQ-008 B  input  WIDTH  multiplier.
REQ-009 signed_op  input  1  1: A and B are two's complement; 0: A and B are unsigned.
REQ-010 out_valid  output  1  P holds a completed product.
REQ-011 out_ready  input  1  consumer takes P.
REQ-012 P  output  2*WIDTH  product.

Function
REQ-013 The block SHALL have exactly three states: IDLE, CALC and DONE.
REQ-014 in_ready SHALL equal 1 in IDLE only; out_valid SHALL equal 1 in DONE only.
REQ-015 Accept: an edge with in_valid=1 in IDLE SHALL capture A, B and signed_op and move the block to CALC; A, B and signed_op changes at any other time SHALL have no effect.
REQ-016 CALC SHALL work on magnitudes: |A| and |B| when signed_op=1, the raw values otherwise.
REQ-017 Each CALC edge SHALL retire BITS_PER_CYCLE bits of |B|, LSB first, by shift-add into a 2*WIDTH accumulator.
REQ-018 After N = WIDTH/BITS_PER_CYCLE CALC edges, the block SHALL enter DONE.
REQ-019 out_valid SHALL rise exactly N edges after the accepting edge.
REQ-020 On entry to DONE, when signed_op=1 and the signs of A and B differ, P SHALL be the two's-complement negation of the accumulator; otherwise P SHALL be the accumulator.
REQ-021 P SHALL equal the exact 2*WIDTH-bit product, with no overflow, for every operand pair in both modes, including the most-negative operands (-2^(WIDTH-1) in either or both inputs).
REQ-022 P and out_valid SHALL be held stable in DONE while out_ready=0.
REQ-023 An edge in DONE with out_ready=1 SHALL move the block to IDLE.
REQ-024 P SHALL retain its last value in IDLE and CALC.
REQ-025 The maximum throughput SHALL be one product per N+2 cycles.
REQ-026 in_valid asserted during CALC or DONE SHALL be ignored; the source SHALL hold in_valid until in_ready=1.

Reset
REQ-027 While rst=1 the block SHALL be in IDLE, with in_ready=1, out_valid=0, P=0, and accumulator and counter cleared; no clock edge is required.
REQ-028 Reset asserted in CALC or DONE SHALL discard the operation in progress without producing any output.
REQ-029 The first accept SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-030 The macro SEQ_MULTIPLIER_EARLY_EXIT_EN, when defined, SHALL make CALC enter DONE on the first edge after which the unretired bits of |B| are all zero; latency is then ceil((msb_index(|B|)+1)/BITS_PER_CYCLE), with a minimum of 1 (|B|=0 gives 1).
REQ-031 Without SEQ_MULTIPLIER_EARLY_EXIT_EN, latency SHALL always be N; the product values SHALL be identical in both builds.

Verification
REQ-032 WIDTH=8, BPC=1, unsigned, A=255, B=255, out_ready=1 -> P=0xFE01, out_valid 8 edges after accept, in_ready back to 1 one edge later.
REQ-033 WIDTH=8, BPC=2, signed, A=0x80, B=0x80 -> P=0x4000; A=0x80, B=0x01 -> P=0xFF80; A=0xFD (-3), B=0x07 -> P=0xFFEB; each with latency 4.
REQ-034 Backpressure: out_ready=0 for 5 cycles in DONE with A=12, B=10 -> P=120 stays stable and out_valid stays 1; in_valid pulses during this time are ignored; the next accept happens only after out_ready=1.
REQ-035 Reset mid-CALC (3rd edge, A=9, B=9) -> out_valid=0, P=0 and in_ready=1 immediately and asynchronously; a following A=2, B=3 gives P=6.
REQ-036 With SEQ_MULTIPLIER_EARLY_EXIT_EN, WIDTH=8, BPC=1: B=0 -> latency 1, P=0; B=3, A=5 -> latency 2, P=15; without the macro both cases take 8 edges.
REQ-037 A randomised run of 1000 operand pairs in both modes, for WIDTH in {4, 8, 16} and BPC in {1, 2, 4}, SHALL match a reference product with zero mismatches.

Source files
------------

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier (IDLE/CALC/DONE) with valid/ready handshakes on both sides.
// Define SEQ_MULTIPLIER_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are all zero.
module seq_multiplier #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 signed_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   P
);

    localparam int PW = 2 * WIDTH;
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    if ((WIDTH < 4) || (WIDTH > 32) ||
        !((BITS_PER_CYCLE == 1) || (BITS_PER_CYCLE == 2) || (BITS_PER_CYCLE == 4)) ||
        ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_bad_param
        $error("seq_multiplier: illegal WIDTH/BITS_PER_CYCLE combination");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [PW-1:0]       r_mcand;
    logic [PW-1:0]       r_acc;
    logic [PW-1:0]       r_p;
    logic [WIDTH-1:0]    r_mplier;
    logic [CW-1:0]       r_cnt;
    logic                r_neg;

    logic [WIDTH-1:0]    w_a_mag;
    logic [WIDTH-1:0]    w_b_mag;
    logic [PW-1:0]       w_pp [BITS_PER_CYCLE];
    logic [PW-1:0]       w_partial;
    logic [PW-1:0]       w_acc_next;
    logic [PW-1:0]       w_prod;
    logic [WIDTH-1:0]    w_mplier_next;
    logic                w_last;
    logic                w_accept;
    logic                w_finish;

    // The magnitude of the most-negative value is its own bit pattern read as unsigned.
    assign w_a_mag = (signed_op && A[WIDTH-1]) ? (~A + 1'b1) : A;
    assign w_b_mag = (signed_op && B[WIDTH-1]) ? (~B + 1'b1) : B;

    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
        assign w_pp[gi] = r_mplier[gi] ? (r_mcand << gi) : '0;
    end

    always_comb begin
        w_partial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            w_partial = w_partial + w_pp[i];
        end
    end

    assign w_acc_next    = r_acc + w_partial;
    assign w_mplier_next = r_mplier >> BITS_PER_CYCLE;
    assign w_prod        = r_neg ? (~w_acc_next + 1'b1) : w_acc_next;
    assign P             = r_p;

`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
    assign w_last = (r_cnt == LAST_CNT) || (w_mplier_next == '0);
`else
    assign w_last = (r_cnt == LAST_CNT);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_finish     = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Product register only loads on the CALC->DONE edge, so it holds through IDLE and CALC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_p      <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mcand  <= PW'(w_a_mag);
                r_mplier <= w_b_mag;
                r_acc    <= '0;
                r_cnt    <= '0;
                r_neg    <= signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
            end else if (r_state == CALC) begin
                r_mcand  <= r_mcand << BITS_PER_CYCLE;
                r_mplier <= w_mplier_next;
                r_acc    <= w_acc_next;
                r_cnt    <= r_cnt + 1'b1;
            end
            if (w_finish) begin
                r_p <= w_prod;
            end
        end
    end

endmodule
